program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Upstream of the ARM CPU core; replaces backdoor program loading with synthesizable logic.
- Accepts a stream of 32-bit program words and writes each word to the instruction and data memories at sequential word addresses.
- Seeds SP (R13) and LR (R14) through a register-file write port, then releases the CPU from reset.
- Monitors the CPU PC and halts the CPU once the PC leaves the loaded program image.

Parameters:
- ADDR_WIDTH, 20, word-address width; capacity 2^ADDR_WIDTH words (4 MB at the default).
- SP_INIT, 32'h003FFFFC, value written to R13.
- LR_INIT, 32'h00400000, value written to R14; lies outside memory, so a final return halts the CPU.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- s_valid  input  1  program word valid.
- s_ready  output  1  loader accepts a word.
- s_data  input  32  program word.
- s_last  input  1  marks the final word of the image.
- mem_we  output  1  write strobe, shared by imem and dmem.
- mem_addr  output  32  byte address = word_index*4.
- mem_wdata  output  32  word to write.
- reg_we  output  1  register-file write strobe.
- reg_addr  output  4  register index.
- reg_wdata  output  32  register write data.
- cpu_reset  output  1  active-high reset to the CPU core.
- cpu_pc  input  32  current CPU PC.
- word_count  output  ADDR_WIDTH+1  number of words loaded.
- done  output  1  program finished; CPU held in reset.
- error  output  1  image overflow.

Behaviour:
- States: LOAD, SET_SP, SET_LR, RUN, HALT, ERROR.
- Reset asserted (reset=0), effective immediately:
  - state=LOAD, word_count=0, cpu_reset=1, done=0, error=0.
  - mem_we=0, reg_we=0, mem_addr=0, mem_wdata=0, reg_addr=0, reg_wdata=0.
  - s_ready=0 while reset is asserted, then 1 in LOAD.
- Reset assertion mid-operation aborts any state and returns to LOAD. Previously written memory contents are not cleared.
- LOAD:
  - s_ready=1.
  - A beat is accepted on a rising edge with s_valid&&s_ready.
  - The accepted beat registers mem_we=1, mem_addr={word_count,2'b00} zero-extended to 32 bits, mem_wdata=s_data. The write is visible in the cycle after acceptance (1-cycle latency).
  - word_count increments by 1.
  - mem_we returns to 0 in any cycle following a non-accepting cycle.
  - Accepted beat with s_last=1 → SET_SP. s_ready drops to 0 the cycle after.
  - A beat presented when word_count==2^ADDR_WIDTH is not written → ERROR.
- SET_SP: one cycle with reg_we=1, reg_addr=13, reg_wdata=SP_INIT → SET_LR.
- SET_LR: one cycle with reg_we=1, reg_addr=14, reg_wdata=LR_INIT → RUN.
- RUN:
  - cpu_reset=0 from the first RUN cycle.
  - The PC check is disabled in the first RUN cycle, while the PC is still at its reset value.
  - From the second RUN cycle onward, cpu_pc >= {word_count,2'b00} (unsigned 32-bit compare) → HALT on the next edge.
  - cpu_reset=1 and done=1 are registered, one cycle after the offending PC.
- HALT: cpu_reset=1, done=1, s_ready=0. Stays here until reset.
- ERROR: error=1, cpu_reset=1, s_ready=0. Stays here until reset.
- s_last on a beat that is not accepted has no effect.
- An image must contain at least one word; a single-word image runs (PC 0) and halts at PC 4.
- reg_we and mem_we are never asserted in the same cycle.

Test Plan:
- Load 3 words 0xE3A00005, 0xE2801001, 0xE12FFF1E with s_last on the 3rd:
  - mem writes to addresses 0x0, 0x4, 0x8 with matching data.
  - word_count=3.
  - R13=0x003FFFFC, then R14=0x00400000 on the next two cycles.
  - cpu_reset falls on the following cycle.
- Backpressure-free gaps: toggle s_valid 1/0 for 4 words → exactly 4 mem_we pulses, contiguous addresses 0x0–0xC, no duplicated or skipped address.
- Run then halt: after RUN, drive cpu_pc = 0x0, 0x4, 0x8, then 0x00400000 → done=1 and cpu_reset=1 exactly one cycle after 0x00400000 is presented; no halt on earlier values.
- Overflow: with ADDR_WIDTH=2, send 5 words without s_last → 4 writes (0x0–0xC); the 5th beat raises error=1 and is not written; s_ready=0 afterwards.
- Reset mid-RUN: pull reset low asynchronously between clock edges → cpu_reset=1, word_count=0, state LOAD and s_ready=1 after release; a fresh 1-word load writes address 0x0.
- Single-word image: load one word with s_last → SP/LR writes, RUN; cpu_pc=0x4 → done=1.

Source files
------------

// File: rtl/program_loader.sv
// Streams a program image into imem/dmem, seeds SP and LR through the register-file
// write port, releases the CPU and halts it once its PC leaves the loaded image.
module program_loader #(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter logic [31:0] SP_INIT    = 32'h003F_FFFC,
  parameter logic [31:0] LR_INIT    = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [31:0]           s_data,
  input  logic                  s_last,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  reg_we,
  output logic [3:0]            reg_addr,
  output logic [31:0]           reg_wdata,
  output logic                  cpu_reset,
  input  logic [31:0]           cpu_pc,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_LOAD,
    S_SET_SP,
    S_SET_LR,
    S_RUN,
    S_HALT,
    S_ERROR
  } state_e;

  localparam logic [ADDR_WIDTH:0] COUNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] COUNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [3:0]          REG_SP     = 4'd13;
  localparam logic [3:0]          REG_LR     = 4'd14;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
  logic                  s_ready_q, s_ready_d;
  logic                  mem_we_q, mem_we_d;
  logic [31:0]           mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  reg_we_q, reg_we_d;
  logic [3:0]            reg_addr_q, reg_addr_d;
  logic [31:0]           reg_wdata_q, reg_wdata_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  pc_check_q, pc_check_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [31:0]           image_end;

  // Byte address one past the last loaded word; also the next write address.
  assign image_end = 32'({word_count_q, 2'b00});

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case infers a latch.
    state_d      = state_q;
    word_count_d = word_count_q;
    s_ready_d    = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    reg_we_d     = 1'b0;
    reg_addr_d   = reg_addr_q;
    reg_wdata_d  = reg_wdata_q;
    cpu_reset_d  = cpu_reset_q;
    pc_check_d   = pc_check_q;
    done_d       = done_q;
    error_d      = error_q;

    unique case (state_q)
      S_LOAD: begin
        s_ready_d = 1'b1;
        if (s_valid && s_ready_q) begin
          if (word_count_q == COUNT_FULL) begin
            state_d   = S_ERROR;
            error_d   = 1'b1;
            s_ready_d = 1'b0;
          end else begin
            mem_we_d     = 1'b1;
            mem_addr_d   = image_end;
            mem_wdata_d  = s_data;
            word_count_d = word_count_q + COUNT_ONE;
            if (s_last) begin
              state_d   = S_SET_SP;
              s_ready_d = 1'b0;
            end
          end
        end
      end
      // Register writes are issued one cycle after the state that owns them, so the
      // final image write and the SP write never share a cycle.
      S_SET_SP: begin
        reg_we_d    = 1'b1;
        reg_addr_d  = REG_SP;
        reg_wdata_d = SP_INIT;
        state_d     = S_SET_LR;
      end
      S_SET_LR: begin
        reg_we_d    = 1'b1;
        reg_addr_d  = REG_LR;
        reg_wdata_d = LR_INIT;
        state_d     = S_RUN;
      end
      S_RUN: begin
        if (cpu_reset_q) begin
          cpu_reset_d = 1'b0;
        end else if (!pc_check_q) begin
          // First released cycle: the CPU PC still holds its reset value.
          pc_check_d = 1'b1;
        end else if (cpu_pc >= image_end) begin
          state_d     = S_HALT;
          cpu_reset_d = 1'b1;
          done_d      = 1'b1;
        end
      end
      S_HALT:  state_d = S_HALT;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_LOAD;
      word_count_q <= '0;
      s_ready_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      reg_we_q     <= 1'b0;
      reg_addr_q   <= '0;
      reg_wdata_q  <= '0;
      cpu_reset_q  <= 1'b1;
      pc_check_q   <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge values.
      state_q      <= state_d;
      word_count_q <= word_count_d;
      s_ready_q    <= s_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      reg_we_q     <= reg_we_d;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      pc_check_q   <= pc_check_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign reg_we     = reg_we_q;
  assign reg_addr   = reg_addr_q;
  assign reg_wdata  = reg_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign word_count = word_count_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: random images and PC traces checked against
// a simple image/halt model, plus an ADDR_WIDTH=2 instance for the overflow case.
module tb_program_loader;

  localparam logic [31:0] SP_EXP = 32'h003F_FFFC;
  localparam logic [31:0] LR_EXP = 32'h0040_0000;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;

  logic        s_valid, s_ready, s_last, mem_we, reg_we, cpu_reset, done, error;
  logic [31:0] s_data, mem_addr, mem_wdata, reg_wdata, cpu_pc;
  logic [3:0]  reg_addr;
  logic [20:0] word_count;

  logic        s_valid_s, s_ready_s, s_last_s, mem_we_s, reg_we_s, cpu_reset_s, done_s, error_s;
  logic [31:0] s_data_s, mem_addr_s, mem_wdata_s, reg_wdata_s, cpu_pc_s;
  logic [3:0]  reg_addr_s;
  logic [2:0]  word_count_s;

  program_loader dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .cpu_reset(cpu_reset), .cpu_pc(cpu_pc), .word_count(word_count),
    .done(done), .error(error)
  );

  program_loader #(.ADDR_WIDTH(2)) dut_small (
    .clk(clk), .reset(reset),
    .s_valid(s_valid_s), .s_ready(s_ready_s), .s_data(s_data_s), .s_last(s_last_s),
    .mem_we(mem_we_s), .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s),
    .reg_we(reg_we_s), .reg_addr(reg_addr_s), .reg_wdata(reg_wdata_s),
    .cpu_reset(cpu_reset_s), .cpu_pc(cpu_pc_s), .word_count(word_count_s),
    .done(done_s), .error(error_s)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Monitor state, sampled 1 time unit after each rising edge.
  int          cyc          = 0;
  int          last_mem_cyc = -1;
  int          rel_cyc      = -1;
  int          overlap      = 0;
  logic        prev_cpu_rst = 1'b1;
  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  logic [3:0]  obs_reg_addr[$];
  logic [31:0] obs_reg_data[$];
  int          obs_reg_cyc[$];
  logic [31:0] obs_addr_s[$];

  // Stimulus / model state.
  logic [31:0] img[$];
  logic [31:0] pcs[$];

  always @(posedge clk) begin
    #1;
    cyc++;
    if (mem_we === 1'b1) begin
      obs_addr.push_back(mem_addr);
      obs_data.push_back(mem_wdata);
      last_mem_cyc = cyc;
    end
    if (reg_we === 1'b1) begin
      obs_reg_addr.push_back(reg_addr);
      obs_reg_data.push_back(reg_wdata);
      obs_reg_cyc.push_back(cyc);
    end
    if (mem_we === 1'b1 && reg_we === 1'b1) overlap++;
    if (mem_we_s === 1'b1 && reg_we_s === 1'b1) overlap++;
    if (prev_cpu_rst === 1'b1 && cpu_reset === 1'b0) rel_cyc = cyc;
    prev_cpu_rst = cpu_reset;
    if (mem_we_s === 1'b1) obs_addr_s.push_back(mem_addr_s);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  // Reference model: word i of the image lives at byte address 4*i, and a PC at or
  // beyond 4*(image length) means the program has left its image.
  function automatic logic [31:0] exp_addr(input int idx);
    return 32'(idx) * 32'd4;
  endfunction

  function automatic logic exp_halt(input logic [31:0] pc, input int nwords);
    return {32'd0, pc} >= (64'(nwords) * 64'd4);
  endfunction

  task automatic clear_obs();
    obs_addr.delete();
    obs_data.delete();
    obs_reg_addr.delete();
    obs_reg_data.delete();
    obs_reg_cyc.delete();
    obs_addr_s.delete();
    last_mem_cyc = -1;
    rel_cyc      = -1;
  endtask

  task automatic idle_inputs();
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; cpu_pc = '0;
    s_valid_s = 1'b0; s_data_s = '0; s_last_s = 1'b0; cpu_pc_s = '0;
  endtask

  task automatic do_reset();
    int budget = 10;
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    while (!(s_ready === 1'b1 && s_ready_s === 1'b1) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      checks++;
      $display("FAIL reset_ready_timeout: s_ready=%b s_ready_small=%b required 1", s_ready, s_ready_s);
    end
    clear_obs();
  endtask

  // Presents one beat and holds it until the loader takes it; returns at the falling
  // edge after the accepting rising edge with s_valid dropped.
  task automatic drive_beat(input logic [31:0] d, input logic last);
    int budget = 20;
    s_valid = 1'b1; s_data = d; s_last = last;
    while (s_ready !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      checks++;
      $display("FAIL beat_timeout: s_ready=%b required 1", s_ready);
    end
    @(negedge clk);
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
  endtask

  task automatic drive_small_beat(input logic [31:0] d, input logic last);
    int budget = 20;
    s_valid_s = 1'b1; s_data_s = d; s_last_s = last;
    while (s_ready_s !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      checks++;
      $display("FAIL small_beat_timeout: s_ready=%b required 1", s_ready_s);
    end
    @(negedge clk);
    s_valid_s = 1'b0; s_data_s = '0; s_last_s = 1'b0;
  endtask

  task automatic load_image(input int gap_min, input int gap_max);
    for (int i = 0; i < img.size(); i++) begin
      drive_beat(img[i], i == img.size() - 1);
      if (i < img.size() - 1) repeat ($urandom_range(gap_max, gap_min)) @(negedge clk);
    end
  endtask

  task automatic check_writes(input string tag);
    checks++;
    if (obs_addr.size() != img.size())
      $display("FAIL %s_write_count: got %0d writes required %0d", tag, obs_addr.size(), img.size());
    else passed++;
    for (int i = 0; i < img.size() && i < obs_addr.size(); i++) begin
      checks++;
      if (obs_addr[i] !== exp_addr(i) || obs_data[i] !== img[i])
        $display("FAIL %s_write%0d: got addr %h data %h required addr %h data %h",
                 tag, i, obs_addr[i], obs_data[i], exp_addr(i), img[i]);
      else passed++;
    end
    checks++;
    if (word_count !== 21'(img.size()))
      $display("FAIL %s_word_count: got %0d required %0d", tag, word_count, img.size());
    else passed++;
  endtask

  // Waits for the CPU release and checks the SP/LR writes and their timing relative
  // to the final image write. Returns in the first released cycle.
  task automatic check_boot(input string tag);
    int budget = 20;
    while (rel_cyc < 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if (rel_cyc < 0) $display("FAIL %s_release_timeout: cpu_reset=%b required 0", tag, cpu_reset);
    else passed++;
    checks++;
    if (obs_reg_addr.size() != 2)
      $display("FAIL %s_reg_write_count: got %0d required 2", tag, obs_reg_addr.size());
    else passed++;
    if (obs_reg_addr.size() == 2) begin
      checks++;
      if (obs_reg_addr[0] !== 4'd13 || obs_reg_data[0] !== SP_EXP ||
          obs_reg_addr[1] !== 4'd14 || obs_reg_data[1] !== LR_EXP)
        $display("FAIL %s_sp_lr: got R%0d=%h R%0d=%h required R13=%h R14=%h", tag,
                 obs_reg_addr[0], obs_reg_data[0], obs_reg_addr[1], obs_reg_data[1], SP_EXP, LR_EXP);
      else passed++;
      checks++;
      if (obs_reg_cyc[0] != last_mem_cyc + 1 || obs_reg_cyc[1] != last_mem_cyc + 2 ||
          rel_cyc != last_mem_cyc + 3)
        $display("FAIL %s_boot_timing: got sp@+%0d lr@+%0d release@+%0d required +1 +2 +3", tag,
                 obs_reg_cyc[0] - last_mem_cyc, obs_reg_cyc[1] - last_mem_cyc, rel_cyc - last_mem_cyc);
      else passed++;
    end
    checks++;
    if (done !== 1'b0 || error !== 1'b0)
      $display("FAIL %s_flags_at_run: got done=%b error=%b required 0 0", tag, done, error);
    else passed++;
  endtask

  // Starts in the first released cycle: a wild PC there must be ignored, then each
  // PC in pcs and finally final_pc is judged against the image-bounds model.
  task automatic run_and_halt(input string tag, input logic [31:0] final_pc);
    logic halted = 1'b0;
    cpu_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || cpu_reset !== 1'b0)
      $display("FAIL %s_first_cycle_pc: got done=%b cpu_reset=%b required 0 0", tag, done, cpu_reset);
    else passed++;
    for (int i = 0; i <= pcs.size(); i++) begin
      cpu_pc = (i < pcs.size()) ? pcs[i] : final_pc;
      halted = halted | exp_halt(cpu_pc, img.size());
      @(negedge clk);
      checks++;
      if (done !== halted || cpu_reset !== halted)
        $display("FAIL %s_pc_%h: got done=%b cpu_reset=%b required %b %b", tag, cpu_pc,
                 done, cpu_reset, halted, halted);
      else passed++;
    end
    cpu_pc = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (done !== halted || cpu_reset !== halted || s_ready !== 1'b0)
      $display("FAIL %s_halt_sticky: got done=%b cpu_reset=%b s_ready=%b required %b %b 0",
               tag, done, cpu_reset, s_ready, halted, halted);
    else passed++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b0 || cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0)
      $display("FAIL reset_ctrl: got s_ready=%b cpu_reset=%b done=%b error=%b required 0 1 0 0",
               s_ready, cpu_reset, done, error);
    else passed++;
    checks++;
    if (mem_we !== 1'b0 || reg_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 ||
        reg_addr !== '0 || reg_wdata !== '0 || word_count !== '0)
      $display("FAIL reset_data: got mem_we=%b reg_we=%b addr=%h wdata=%h raddr=%h rdata=%h count=%0d required zeros",
               mem_we, reg_we, mem_addr, mem_wdata, reg_addr, reg_wdata, word_count);
    else passed++;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || s_ready_s !== 1'b1 || cpu_reset !== 1'b1)
      $display("FAIL reset_release: got s_ready=%b small=%b cpu_reset=%b required 1 1 1",
               s_ready, s_ready_s, cpu_reset);
    else passed++;
    clear_obs();
  endtask

  task automatic test_three_word();
    do_reset();
    img = '{32'hE3A0_0005, 32'hE280_1001, 32'hE12F_FF1E};
    load_image(0, 0);
    check_writes("three_word");
    check_boot("three_word");
    pcs = '{32'h0, 32'h4, 32'h8};
    run_and_halt("three_word", 32'h0040_0000);
  endtask

  task automatic test_gaps();
    do_reset();
    img.delete();
    for (int i = 0; i < 4; i++) img.push_back($urandom);
    load_image(1, 1);
    check_writes("gaps");
  endtask

  task automatic test_random_images();
    for (int t = 0; t < 4; t++) begin
      int n;
      do_reset();
      n = $urandom_range(6, 1);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back($urandom);
      load_image(0, 2);
      check_writes("random");
      check_boot("random");
      pcs.delete();
      for (int i = 0; i < $urandom_range(4, 1); i++) pcs.push_back(exp_addr($urandom_range(n - 1, 0)));
      run_and_halt("random", exp_addr(n + $urandom_range(3, 0)));
    end
  endtask

  task automatic test_single_word();
    do_reset();
    img = '{$urandom};
    load_image(0, 0);
    check_writes("single");
    check_boot("single");
    pcs = '{32'h0};
    run_and_halt("single", 32'h4);
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) drive_small_beat($urandom, 1'b0);
    checks++;
    if (error_s !== 1'b1 || s_ready_s !== 1'b0 || mem_we_s !== 1'b0)
      $display("FAIL overflow_flags: got error=%b s_ready=%b mem_we=%b required 1 0 0",
               error_s, s_ready_s, mem_we_s);
    else passed++;
    checks++;
    if (obs_addr_s.size() != 4 || word_count_s !== 3'd4)
      $display("FAIL overflow_count: got %0d writes count=%0d required 4 4", obs_addr_s.size(), word_count_s);
    else passed++;
    for (int i = 0; i < obs_addr_s.size(); i++) begin
      checks++;
      if (obs_addr_s[i] !== exp_addr(i))
        $display("FAIL overflow_addr%0d: got %h required %h", i, obs_addr_s[i], exp_addr(i));
      else passed++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (error_s !== 1'b1 || cpu_reset_s !== 1'b1 || s_ready_s !== 1'b0 || obs_addr_s.size() != 4)
      $display("FAIL overflow_sticky: got error=%b cpu_reset=%b s_ready=%b writes=%0d required 1 1 0 4",
               error_s, cpu_reset_s, s_ready_s, obs_addr_s.size());
    else passed++;
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    img = '{$urandom, $urandom};
    load_image(0, 0);
    check_boot("mid_run");
    cpu_pc = 32'h4;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (cpu_reset !== 1'b1 || word_count !== '0 || done !== 1'b0 || s_ready !== 1'b0)
      $display("FAIL mid_run_async: got cpu_reset=%b count=%0d done=%b s_ready=%b required 1 0 0 0",
               cpu_reset, word_count, done, s_ready);
    else passed++;
    @(posedge clk);
    #3 reset = 1'b1;
    cpu_pc = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || cpu_reset !== 1'b1 || word_count !== '0)
      $display("FAIL mid_run_release: got s_ready=%b cpu_reset=%b count=%0d required 1 1 0",
               s_ready, cpu_reset, word_count);
    else passed++;
    clear_obs();
    img = '{$urandom};
    load_image(0, 0);
    check_writes("mid_run_reload");
  endtask

  task automatic test_exclusive_strobes();
    checks++;
    if (overlap != 0)
      $display("FAIL strobe_overlap: got %0d cycles with mem_we and reg_we together required 0", overlap);
    else passed++;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_three_word();
    test_gaps();
    test_random_images();
    test_single_word();
    test_overflow();
    test_reset_mid_run();
    test_exclusive_strobes();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
